cam: RTL and testbench

Content-addressable memory of 2^ADDR_WIDTH entries × DATA_WIDTH bits, used as the lookup store for credential keys. A word is written at an explicit address. A search then presents a key on the same data bus and returns whether any valid entry holds that key, and at which address. Comparison is done per slice of SLICE_WIDTH bits; an entry matches only when every slice matches.

---
 rtl/cam.sv | 88 ++++++++
 tb/tb_cam.sv | 131 +++++++++++++
 2 files changed

// File: rtl/cam.sv
// Content-addressable memory: explicit-address writes, single-cycle parallel
// search with lowest-index priority, registered match/match_addr outputs.
module cam #(
  parameter int DATA_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 6,
  parameter int SLICE_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  output logic                  match,
  output logic [ADDR_WIDTH-1:0] match_addr
);

  localparam int ENTRIES = 2 ** ADDR_WIDTH;
  localparam int SLICES  = DATA_WIDTH / SLICE_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [ENTRIES];
  logic [ENTRIES-1:0]    valid_r;
  logic [ENTRIES-1:0]    hit_s;
  logic                  search_s;

  function automatic logic [ADDR_WIDTH-1:0] encode_lowest(input logic [ENTRIES-1:0] vec);
    logic [ADDR_WIDTH-1:0] idx;
    idx = '0;
    for (int e = ENTRIES - 1; e >= 0; e--) begin
      if (vec[e]) begin
        idx = ADDR_WIDTH'(e);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  assign search_s = start & ~write_enable;

  // Data words carry no reset; unwritten entries are masked by valid_r.
  always_ff @(posedge clk) begin
    if (write_enable) begin
      mem_r[write_addr] <= din;
    end
  end

  // Valid bits: set on write, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= '0;
    end else if (write_enable) begin
      valid_r[write_addr] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Per-entry hit: valid and every slice equal to the key.
  always_comb begin
    hit_s = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      hit_s[e] = valid_r[e];
      for (int s = 0; s < SLICES; s++) begin
        if (mem_r[e][s*SLICE_WIDTH +: SLICE_WIDTH] != din[s*SLICE_WIDTH +: SLICE_WIDTH]) begin
          hit_s[e] = 1'b0;
        end else begin
          hit_s[e] = hit_s[e];
        end
      end
    end
  end

  // Search result register; any non-search cycle forces outputs to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match      <= 1'b0;
      match_addr <= '0;
    end else if (search_s && (|hit_s)) begin
      match      <= 1'b1;
      match_addr <= encode_lowest(hit_s);
    end else begin
      match      <= 1'b0;
      match_addr <= '0;
    end
  end

endmodule

// File: tb/tb_cam.sv
// Self-checking bench for cam: directed test-plan steps followed by random
// operations, all compared against an array-based reference model.
module tb_cam;
  localparam int DW = 128;
  localparam int AW = 6;
  localparam int N  = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          write_enable;
  logic [DW-1:0] din;
  logic [AW-1:0] write_addr;
  logic          match;
  logic [AW-1:0] match_addr;

  logic [DW-1:0] ref_mem [N];
  bit            ref_valid [N];
  logic [DW-1:0] pool [8];
  int total = 0;
  int bad   = 0;

  cam #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLICE_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .write_enable(write_enable),
    .din(din), .write_addr(write_addr), .match(match), .match_addr(match_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic exp_m, input logic [AW-1:0] exp_a);
    total++;
    assert (match === exp_m) else begin
      bad++;
      $error("FAIL %s match observed=%0b expected=%0b", tag, match, exp_m);
    end
    total++;
    assert (match_addr === exp_a) else begin
      bad++;
      $error("FAIL %s match_addr observed=%0d expected=%0d", tag, match_addr, exp_a);
    end
  endtask

  // One clocked operation; expected result computed from the model before it updates.
  task automatic op(input string tag, input logic s, input logic w,
                    input logic [DW-1:0] d, input logic [AW-1:0] a);
    logic          em;
    logic [AW-1:0] ea;
    em = 1'b0;
    ea = '0;
    if (s && !w) begin
      for (int e = 0; e < N; e++) begin
        if (!em && ref_valid[e] && ref_mem[e] == d) begin
          em = 1'b1;
          ea = AW'(e);
        end
      end
    end
    if (w) begin
      ref_mem[a]   = d;
      ref_valid[a] = 1'b1;
    end
    @(negedge clk);
    start        = s;
    write_enable = w;
    din          = d;
    write_addr   = a;
    @(posedge clk);
    #1;
    check(tag, em, ea);
  endtask

  initial begin
    logic [DW-1:0] k63;
    logic [DW-1:0] kk;
    logic [DW-1:0] key;
    k63 = 128'hDEADBEEF_01234567_89ABCDEF_FEEDF00D;
    kk  = 128'h0BADCAFE_11223344_55667788_99AABBCC;
    for (int e = 0; e < N; e++) ref_valid[e] = 1'b0;
    rst = 1'b0; start = 1'b0; write_enable = 1'b0; din = '0; write_addr = '0;
    #12;
    check("reset", 1'b0, 6'd0);
    @(negedge clk);
    rst = 1'b1;

    op("empty_zero_key", 1'b1, 1'b0, 128'h0, 6'd0);
    op("wr0", 1'b0, 1'b1, 128'h0, 6'd0);
    op("wr1", 1'b0, 1'b1, 128'h0, 6'd1);
    op("zero_priority", 1'b1, 1'b0, 128'h0, 6'd0);
    op("miss_1111", 1'b1, 1'b0, 128'h1111_1111_1111_1111_1111_1111_1111_1111, 6'd0);
    op("idle", 1'b0, 1'b0, 128'h0, 6'd0);
    op("wr63", 1'b0, 1'b1, k63, 6'd63);
    op("wr5", 1'b0, 1'b1, ~k63, 6'd5);
    op("hit63", 1'b1, 1'b0, k63, 6'd0);
    op("hit5", 1'b1, 1'b0, ~k63, 6'd0);
    op("overwrite63", 1'b0, 1'b1, k63 ^ 128'h5, 6'd63);
    op("old_key_miss", 1'b1, 1'b0, k63, 6'd0);
    op("top_slice_diff", 1'b1, 1'b0, ~k63 ^ {4'h1, 124'h0}, 6'd0);
    op("bit0_diff", 1'b1, 1'b0, ~k63 ^ 128'h1, 6'd0);
    op("wr_and_search", 1'b1, 1'b1, kk, 6'd9);
    op("search_k", 1'b1, 1'b0, kk, 6'd0);

    // Reset asserted mid-search must drop outputs without a clock edge.
    @(negedge clk);
    start = 1'b1; write_enable = 1'b0; din = kk;
    @(posedge clk);
    #1;
    check("pre_reset_hit", 1'b1, 6'd9);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", 1'b0, 6'd0);
    for (int e = 0; e < N; e++) ref_valid[e] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    op("after_reset_miss", 1'b1, 1'b0, kk, 6'd0);

    for (int i = 0; i < 8; i++) pool[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 400; i++) begin
      logic s;
      logic w;
      s   = 1'($urandom_range(0, 1));
      w   = ($urandom_range(0, 2) == 0);
      key = pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 5) == 0) key[$urandom_range(0, DW - 1)] ^= 1'b1;
      op("random", s, w, key, AW'($urandom_range(0, N - 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
